// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two ALU requesters and alu_arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface alu_arbiter_if;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_a0, req_a1;
  logic [31:0] req_b0, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_result;
  logic        rsp_zf;
  logic        rsp_err;

  modport slave (
    input  req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
    input  rsp_ready0, rsp_ready1,
    output req_ready0, req_ready1,
    output rsp_valid0, rsp_valid1, rsp_result, rsp_zf, rsp_err
  );

  modport master (
    output req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
    output rsp_ready0, rsp_ready1,
    input  req_ready0, req_ready1,
    input  rsp_valid0, rsp_valid1, rsp_result, rsp_zf, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with op screening.
// Define ALU_ARB_STATS_EN to add saturating grant/error counters (grant_cnt0/1, err_cnt).
module alu_arbiter #(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [31:0]       A_ALU,
    output logic [31:0]       B_ALU,
    output logic [3:0]        sel_ALU,
    input  logic [31:0]       O_ALU
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       err_cnt
`endif
);

    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic          last_grant, owner, grant, hs;
    logic [31:0]   sel_a, sel_b;
    logic [3:0]    sel_op;
    logic          op_illegal, op_div0;
    logic [CW-1:0] cnt, lat_load;
    logic [31:0]   result_q;
    logic          zf_q, err_q;

    always_comb begin
        grant = 1'b0;
        if (bus.req_valid0 && bus.req_valid1) grant = ~last_grant;
        else if (bus.req_valid1)              grant = 1'b1;

        hs     = (state == IDLE) && (bus.req_valid0 || bus.req_valid1);
        sel_a  = grant ? bus.req_a1  : bus.req_a0;
        sel_b  = grant ? bus.req_b1  : bus.req_b0;
        sel_op = grant ? bus.req_op1 : bus.req_op0;

        op_illegal = sel_op > 4'b1000;
        op_div0    = (sel_op == 4'b0011) && (sel_b == '0);

        case (sel_op)
            4'b0010: lat_load = CW'(LAT_MUL - 1);
            4'b0011: lat_load = CW'(LAT_DIV - 1);
            default: lat_load = CW'(LAT_SIMPLE - 1);
        endcase

        bus.req_ready0 = hs && !grant;
        bus.req_ready1 = hs && grant;
        bus.rsp_valid0 = (state == RESP) && !owner;
        bus.rsp_valid1 = (state == RESP) && owner;
        bus.rsp_result = result_q;
        bus.rsp_zf     = zf_q;
        bus.rsp_err    = err_q;

        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = (op_illegal || op_div0) ? RESP : EXEC;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (owner ? bus.rsp_ready1 : bus.rsp_ready0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Screened ops answer straight from IDLE and leave the ALU operand registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            A_ALU      <= '0;
            B_ALU      <= '0;
            sel_ALU    <= '0;
            cnt        <= '0;
            result_q   <= '0;
            zf_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    last_grant <= grant;
                    owner      <= grant;
                    if (op_illegal) begin
                        result_q <= '0;
                        zf_q     <= 1'b1;
                        err_q    <= 1'b1;
                    end else if (op_div0) begin
                        result_q <= '1;
                        zf_q     <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        A_ALU   <= sel_a;
                        B_ALU   <= sel_b;
                        sel_ALU <= sel_op;
                        cnt     <= lat_load;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result_q <= O_ALU;
                        zf_q     <= (O_ALU == '0);
                        err_q    <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (bus.req_ready0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (bus.req_ready1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
            // Only screened ops enter RESP with an error; EXEC always clears it.
            if (hs && (op_illegal || op_div0) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model.
// A behavioural ALU answers O_ALU from A_ALU/B_ALU/sel_ALU.
module tb_alu_arbiter;
    localparam int LAT_SIMPLE = 1;
    localparam int LAT_MUL    = 2;
    localparam int LAT_DIV    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if bus();
    logic [31:0] A_ALU, B_ALU, O_ALU;
    logic [3:0]  sel_ALU;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, err_cnt;
`endif

    alu_arbiter #(.LAT_SIMPLE(LAT_SIMPLE), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .A_ALU(A_ALU), .B_ALU(B_ALU), .sel_ALU(sel_ALU), .O_ALU(O_ALU)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
    );

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 0) ? 32'd0 : a / b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign O_ALU = alu_fn(A_ALU, B_ALU, sel_ALU);

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op, round-robin winner, fixed response latency.
    bit          mon_en = 1'b0;
    bit          last_win = 1'b1;
    bit          pend = 1'b0, pend_port = 1'b0, rsp_seen = 1'b0;
    logic [31:0] pend_res;
    bit          pend_zf, pend_err;
    int          pend_lat, acc_cyc;
    int          cyc = 0;
    int          m_g0 = 0, m_g1 = 0, m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        last_win = 1'b1; pend = 1'b0; rsp_seen = 1'b0;
        m_g0 = 0; m_g1 = 0; m_err = 0;
    endtask

    always @(negedge clk) begin : mon
        logic        w;
        logic [31:0] ma, mb;
        logic [3:0]  mo;
        if (mon_en && rst_n) begin
            check("one_ready", 32'(bus.req_ready0 & bus.req_ready1), 32'd0);
            check("accept", 32'(bus.req_ready0 | bus.req_ready1),
                  32'(!pend && (bus.req_valid0 || bus.req_valid1)));
            if (bus.req_ready0 || bus.req_ready1) begin
                w = bus.req_ready1;
                if (bus.req_valid0 && bus.req_valid1) check("rr", 32'(w), 32'(!last_win));
                last_win = w;
                if (w) m_g1++; else m_g0++;
                ma = w ? bus.req_a1  : bus.req_a0;
                mb = w ? bus.req_b1  : bus.req_b0;
                mo = w ? bus.req_op1 : bus.req_op0;
                if (mo > 4'd8) begin
                    pend_res = 32'd0; pend_err = 1'b1; pend_lat = 1;
                end else if (mo == 4'd3 && mb == 32'd0) begin
                    pend_res = 32'hFFFF_FFFF; pend_err = 1'b1; pend_lat = 1;
                end else begin
                    pend_res = alu_fn(ma, mb, mo); pend_err = 1'b0;
                    pend_lat = 1 + ((mo == 4'd2) ? LAT_MUL : (mo == 4'd3) ? LAT_DIV : LAT_SIMPLE);
                end
                pend_zf = (pend_res == 32'd0);
                pend = 1'b1; pend_port = w; acc_cyc = cyc; rsp_seen = 1'b0;
            end
            if (bus.rsp_valid0 || bus.rsp_valid1) begin
                check("rsp_pend", 32'(pend), 32'd1);
                check("rsp_one", 32'(bus.rsp_valid0 & bus.rsp_valid1), 32'd0);
                check("rsp_port", 32'(bus.rsp_valid1), 32'(pend_port));
                if (!rsp_seen) begin
                    check("latency", 32'(cyc - acc_cyc), 32'(pend_lat));
                    rsp_seen = 1'b1;
                    if (pend_err) m_err++;
                end
                check("result", bus.rsp_result, pend_res);
                check("zf", 32'(bus.rsp_zf), 32'(pend_zf));
                check("err", 32'(bus.rsp_err), 32'(pend_err));
                if (pend_port ? bus.rsp_ready1 : bus.rsp_ready0) begin
                    pend = 1'b0; rsp_seen = 1'b0;
                end
            end else if (pend) begin
                check("rsp_due", 32'((cyc - acc_cyc) < pend_lat && !rsp_seen), 32'd1);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_A", A_ALU, 32'd0);
        check("rst_B", B_ALU, 32'd0);
        check("rst_sel", 32'(sel_ALU), 32'd0);
        check("rst_rv0", 32'(bus.rsp_valid0), 32'd0);
        check("rst_rv1", 32'(bus.rsp_valid1), 32'd0);
        check("rst_res", bus.rsp_result, 32'd0);
        check("rst_zf", 32'(bus.rsp_zf), 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;
        bus.rsp_ready0 = 1'b0; bus.rsp_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_values();
        check("rst_rdy", 32'(bus.req_ready0 | bus.req_ready1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    task automatic wait_grant(output bit w);
        w = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready0 || bus.req_ready1) begin
                w = bus.req_ready1;
                return;
            end
        end
        check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input bit p);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? bus.rsp_valid1 : bus.rsp_valid0) return;
        end
        check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_req(output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
        a  = ($urandom % 2) ? $urandom : ($urandom % 16);
        b  = ($urandom % 4 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : ($urandom % 16));
        op = 4'($urandom % 16);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit w, h0, h1;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
        do_reset();

        // Single add on port 0
        bus.rsp_ready0 = 1'b1;
        bus.req_a0 = 32'd5; bus.req_b0 = 32'd7; bus.req_op0 = 4'b0000; bus.req_valid0 = 1'b1;
        @(negedge clk);
        check("add_ready0", 32'(bus.req_ready0), 32'd1);
        @(posedge clk); #1 bus.req_valid0 = 1'b0;
        @(negedge clk);
        check("add_exec_rv0", 32'(bus.rsp_valid0), 32'd0);
        @(negedge clk);
        check("add_rv0", 32'(bus.rsp_valid0), 32'd1);
        check("add_rv1", 32'(bus.rsp_valid1), 32'd0);
        check("add_res", bus.rsp_result, 32'd12);
        check("add_zf", 32'(bus.rsp_zf), 32'd0);
        check("add_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        check("add_done_rv0", 32'(bus.rsp_valid0), 32'd0);

        // Both ports requesting continuously
        do_reset();
        bus.rsp_ready0 = 1'b1; bus.rsp_ready1 = 1'b1;
        bus.req_a0 = 32'd9;    bus.req_b0 = 32'd9;    bus.req_op0 = 4'b0001;
        bus.req_a1 = 32'hF0;   bus.req_b1 = 32'h0F;   bus.req_op1 = 4'b0101;
        bus.req_valid0 = 1'b1; bus.req_valid1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_grant(w);
            check("alt_grant", 32'(w), 32'(t % 2));
            wait_rsp(w);
            check("alt_res", bus.rsp_result, w ? 32'hFF : 32'd0);
            check("alt_zf", 32'(bus.rsp_zf), w ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1 bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;

        // Divide on port 1: operands held through all EXEC cycles
        bus.req_a1 = 32'd100; bus.req_b1 = 32'd7; bus.req_op1 = 4'b0011; bus.req_valid1 = 1'b1;
        wait_grant(w);
        check("div_port", 32'(w), 32'd1);
        @(posedge clk); #1 bus.req_valid1 = 1'b0;
        for (int i = 0; i < LAT_DIV; i++) begin
            @(negedge clk);
            check("div_A", A_ALU, 32'd100);
            check("div_B", B_ALU, 32'd7);
            check("div_sel", 32'(sel_ALU), 32'd3);
            check("div_rv1", 32'(bus.rsp_valid1), 32'd0);
        end
        @(negedge clk);
        check("div_rv1_up", 32'(bus.rsp_valid1), 32'd1);
        check("div_res", bus.rsp_result, 32'd14);

        // Divide by zero is screened
        @(posedge clk); #1;
        bus.req_a1 = 32'd50; bus.req_b1 = 32'd0; bus.req_valid1 = 1'b1;
        wait_grant(w);
        @(posedge clk); #1 bus.req_valid1 = 1'b0;
        @(negedge clk);
        check("dz_rv1", 32'(bus.rsp_valid1), 32'd1);
        check("dz_res", bus.rsp_result, 32'hFFFF_FFFF);
        check("dz_zf", 32'(bus.rsp_zf), 32'd0);
        check("dz_err", 32'(bus.rsp_err), 32'd1);
        check("dz_A_kept", A_ALU, 32'd100);
        check("dz_B_kept", B_ALU, 32'd7);

        // Illegal opcode on port 0
        @(posedge clk); #1;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_op0 = 4'b1010; bus.req_valid0 = 1'b1;
        wait_grant(w);
        @(posedge clk); #1 bus.req_valid0 = 1'b0;
        @(negedge clk);
        check("ill_rv0", 32'(bus.rsp_valid0), 32'd1);
        check("ill_res", bus.rsp_result, 32'd0);
        check("ill_zf", 32'(bus.rsp_zf), 32'd1);
        check("ill_err", 32'(bus.rsp_err), 32'd1);
        check("ill_sel_kept", 32'(sel_ALU), 32'd3);

        // Response back-pressure with a waiting port-1 request
        @(posedge clk); #1;
        bus.rsp_ready0 = 1'b0;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd2; bus.req_op0 = 4'b0000; bus.req_valid0 = 1'b1;
        wait_grant(w);
        check("bp_port", 32'(w), 32'd0);
        @(posedge clk); #1;
        bus.req_valid0 = 1'b0;
        bus.req_a1 = 32'hF; bus.req_b1 = 32'h3; bus.req_op1 = 4'b0100; bus.req_valid1 = 1'b1;
        wait_rsp(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_rv0", 32'(bus.rsp_valid0), 32'd1);
            check("bp_res", bus.rsp_result, 32'd3);
            check("bp_rdy0", 32'(bus.req_ready0), 32'd0);
            check("bp_rdy1", 32'(bus.req_ready1), 32'd0);
        end
        @(posedge clk); #1 bus.rsp_ready0 = 1'b1;
        @(negedge clk);
        check("bp_last_rdy1", 32'(bus.req_ready1), 32'd0);
        @(negedge clk);
        check("bp_rv0_drop", 32'(bus.rsp_valid0), 32'd0);
        check("bp_rdy1_up", 32'(bus.req_ready1), 32'd1);
        @(posedge clk); #1 bus.req_valid1 = 1'b0;
        wait_rsp(1'b1);
        check("bp_res1", bus.rsp_result, 32'd3);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        bus.req_a0 = 32'd6; bus.req_b0 = 32'd7; bus.req_op0 = 4'b0010; bus.req_valid0 = 1'b1;
        wait_grant(w);
        check("mul_port", 32'(w), 32'd0);
        @(posedge clk); #1 bus.req_valid0 = 1'b0;
        @(negedge clk);
        check("mul_A", A_ALU, 32'd6);
        #1 mon_en = 1'b0; rst_n = 1'b0;
        #1 check_reset_values();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1 mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rv", 32'(bus.rsp_valid0 | bus.rsp_valid1), 32'd0);
        end
        @(posedge clk); #1;
        bus.req_a0 = 32'd2; bus.req_b0 = 32'd2; bus.req_op0 = 4'b0000;
        bus.req_a1 = 32'd3; bus.req_b1 = 32'd3; bus.req_op1 = 4'b0000;
        bus.req_valid0 = 1'b1; bus.req_valid1 = 1'b1;
        @(negedge clk);
        check("post_rst_rdy0", 32'(bus.req_ready0), 32'd1);
        check("post_rst_rdy1", 32'(bus.req_ready1), 32'd0);
        @(posedge clk); #1 bus.req_valid0 = 1'b0;
        wait_grant(w);
        @(posedge clk); #1 bus.req_valid1 = 1'b0;

        // Randomized traffic checked by the model
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            h0 = bus.req_ready0;
            h1 = bus.req_ready1;
            @(posedge clk); #1;
            if (h0) begin
                bus.req_valid0 = ($urandom % 2) != 0;
                rand_req(bus.req_a0, bus.req_b0, bus.req_op0);
            end else if (bus.req_valid0 && ($urandom % 16 == 0)) begin
                bus.req_valid0 = 1'b0;
            end else if (!bus.req_valid0 && ($urandom % 3 == 0)) begin
                bus.req_valid0 = 1'b1;
                rand_req(bus.req_a0, bus.req_b0, bus.req_op0);
            end
            if (h1) begin
                bus.req_valid1 = ($urandom % 2) != 0;
                rand_req(bus.req_a1, bus.req_b1, bus.req_op1);
            end else if (bus.req_valid1 && ($urandom % 16 == 0)) begin
                bus.req_valid1 = 1'b0;
            end else if (!bus.req_valid1 && ($urandom % 3 == 0)) begin
                bus.req_valid1 = 1'b1;
                rand_req(bus.req_a1, bus.req_b1, bus.req_op1);
            end
            bus.rsp_ready0 = ($urandom % 4) != 0;
            bus.rsp_ready1 = ($urandom % 4) != 0;
        end
        bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;
        bus.rsp_ready0 = 1'b1; bus.rsp_ready1 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(pend), 32'd0);
`ifdef ALU_ARB_STATS_EN
        check("stat_g0", 32'(grant_cnt0), 32'(m_g0));
        check("stat_g1", 32'(grant_cnt1), 32'(m_g1));
        check("stat_err", 32'(err_cnt), 32'(m_err));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
